// File: rtl/rmt_stateful_pkg.sv
// Shared definitions for the RMT stateful-ALU memory path: opcodes, FSM states, RAM geometry.
package rmt_stateful_pkg;

    localparam int MEM_DEPTH      = 32;
    localparam int MEM_ADDR_WIDTH = 5;

    localparam logic [7:0] OP_STORE = 8'h08;
    localparam logic [7:0] OP_LOAD  = 8'h0B;
    localparam logic [7:0] OP_LOADD = 8'h07;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        WB   = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a priority pointer that moves past each winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_gnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_d;
    logic             w_found;
    int               w_idx;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_ptr_d = r_ptr;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
                w_ptr_d      = PTR_W'((w_idx + 1) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= w_ptr_d;
        end
    end

endmodule

// File: rtl/stateful_mem_arbiter.sv
// Serializes stateful-ALU load/store/loadd accesses onto one shared RAM with page isolation.
// Optional build macro MEM_ARB_BOUNDS_CHECK_EN enables the page-length bounds check.
module stateful_mem_arbiter
    import rmt_stateful_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int OP_WIDTH   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*OP_WIDTH-1:0]    req_op,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    input  logic [NUM_REQ*16-1:0]          req_page,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic [DATA_WIDTH-1:0]          resp_data,
    output logic                           resp_overflow,
    output logic                           resp_err,
    output logic [ADDR_WIDTH-1:0]          mem_addra,
    output logic [DATA_WIDTH-1:0]          mem_dina,
    output logic                           mem_wea,
    output logic [ADDR_WIDTH-1:0]          mem_addrb,
    input  logic [DATA_WIDTH-1:0]          mem_doutb
);

    state_e r_state;
    state_e w_state_d;

    logic [NUM_REQ-1:0]    w_gnt;
    logic                  w_advance;

    logic [OP_WIDTH-1:0]   w_sel_op;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [15:0]           w_sel_page;
    logic [ADDR_WIDTH-1:0] w_phys;
    logic                  w_ovf;

    logic [NUM_REQ-1:0]    r_gnt;
    logic [OP_WIDTH-1:0]   r_op;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_ovf;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_is_store;
    logic                  w_is_load;
    logic                  w_is_loadd;
    logic                  w_supported;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_write;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .i_req     (req_valid),
        .i_advance (w_advance),
        .o_gnt     (w_gnt)
    );

    always_comb begin
        w_sel_op   = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_page = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_op   = req_op[i*OP_WIDTH +: OP_WIDTH];
                w_sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_page = req_page[i*16 +: 16];
            end
        end
    end

    // Only the low address bits of the base matter; the sum wraps around the RAM.
    assign w_phys = w_sel_page[ADDR_WIDTH-1:0] + w_sel_addr;

`ifdef MEM_ARB_BOUNDS_CHECK_EN
    assign w_ovf = int'(w_sel_addr) > int'(w_sel_page[15:8]);
    logic w_unused_page;
    assign w_unused_page = ^w_sel_page[7:ADDR_WIDTH];
`else
    assign w_ovf = 1'b0;
    logic w_unused_page;
    assign w_unused_page = ^{w_sel_page[15:8], w_sel_page[7:ADDR_WIDTH]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_op    <= '0;
            r_paddr <= '0;
            r_data  <= '0;
            r_ovf   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_advance) begin
                r_gnt   <= w_gnt;
                r_op    <= w_sel_op;
                r_paddr <= w_phys;
                r_data  <= w_sel_data;
                r_ovf   <= w_ovf;
            end
            if (r_state == CAP) begin
                r_rdata <= mem_doutb;
            end
        end
    end

    assign w_is_store  = (r_op == OP_WIDTH'(OP_STORE));
    assign w_is_load   = (r_op == OP_WIDTH'(OP_LOAD));
    assign w_is_loadd  = (r_op == OP_WIDTH'(OP_LOADD));
    assign w_supported = w_is_store || w_is_load || w_is_loadd;
    assign w_write     = (w_is_store || w_is_loadd) && !r_ovf;

    always_comb begin
        w_result = '0;
        if (w_supported && !r_ovf) begin
            if (w_is_store) begin
                w_result = r_data;
            end else if (w_is_loadd) begin
                w_result = r_rdata + DATA_WIDTH'(1);
            end else begin
                w_result = r_rdata;
            end
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_advance     = 1'b0;
        req_ready     = '0;
        resp_valid    = '0;
        resp_data     = '0;
        resp_overflow = 1'b0;
        resp_err      = 1'b0;
        mem_wea       = 1'b0;
        mem_addra     = '0;
        mem_dina      = '0;
        mem_addrb     = '0;
        unique case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_advance = 1'b1;
                    req_ready = w_gnt;
                    w_state_d = RD;
                end
            end
            RD: begin
                // Unsupported opcodes never touch the RAM.
                if (w_supported) begin
                    mem_addrb = r_paddr;
                end
                w_state_d = CAP;
            end
            CAP: begin
                w_state_d = WB;
            end
            WB: begin
                resp_valid    = r_gnt;
                resp_data     = w_result;
                resp_overflow = r_ovf;
                resp_err      = !w_supported;
                if (w_write) begin
                    mem_wea   = 1'b1;
                    mem_addra = r_paddr;
                    mem_dina  = w_result;
                end
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_stateful_mem_arbiter.sv
// Directed bench for stateful_mem_arbiter with a behavioural one-cycle-latency RAM.
module tb_stateful_mem_arbiter;

    localparam logic BC =
`ifdef MEM_ARB_BOUNDS_CHECK_EN
        1'b1;
`else
        1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [31:0]  req_op;
    logic [19:0]  req_addr;
    logic [127:0] req_data;
    logic [63:0]  req_page;
    logic [3:0]   resp_valid;
    logic [31:0]  resp_data;
    logic         resp_overflow;
    logic         resp_err;
    logic [4:0]   mem_addra;
    logic [31:0]  mem_dina;
    logic         mem_wea;
    logic [4:0]   mem_addrb;
    logic [31:0]  mem_doutb;

    logic [31:0]  ram [32];

    int n_checks = 0;
    int n_fail   = 0;

    stateful_mem_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .OP_WIDTH   (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_page      (req_page),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_overflow (resp_overflow),
        .resp_err      (resp_err),
        .mem_addra     (mem_addra),
        .mem_dina      (mem_dina),
        .mem_wea       (mem_wea),
        .mem_addrb     (mem_addrb),
        .mem_doutb     (mem_doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wea) ram[mem_addra] <= mem_dina;
        mem_doutb <= ram[mem_addrb];
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One isolated request from requester r; expectations are passed in by the caller.
    task automatic txn(input int r, input logic [7:0] op, input logic [4:0] addr,
                       input logic [31:0] data, input logic [15:0] page,
                       input logic [4:0] exp_pa, input logic exp_rd,
                       input logic [31:0] exp_data, input logic exp_ovf,
                       input logic exp_err, input logic exp_we);
        int waited;
        logic [3:0] onehot;
        onehot = 4'(1 << r);
        @(negedge clk);
        req_op[r*8 +: 8]    = op;
        req_addr[r*5 +: 5]  = addr;
        req_data[r*32 +: 32] = data;
        req_page[r*16 +: 16] = page;
        req_valid[r]        = 1'b1;
        #1;
        waited = 0;
        while (req_ready == 4'b0 && waited < 8) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check_eq("ready", 32'(req_ready), 32'(onehot));
        if (req_ready == 4'b0) begin
            req_valid[r] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
        @(negedge clk);
        check_eq("rd_addrb", 32'(mem_addrb), exp_rd ? 32'(exp_pa) : 32'd0);
        check_eq("rd_no_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check_eq("wb_resp_valid", 32'(resp_valid), 32'(onehot));
        check_eq("wb_resp_data", resp_data, exp_data);
        check_eq("wb_overflow", 32'(resp_overflow), 32'(exp_ovf));
        check_eq("wb_err", 32'(resp_err), 32'(exp_err));
        check_eq("wb_wea", 32'(mem_wea), 32'(exp_we));
        if (exp_we) begin
            check_eq("wb_addra", 32'(mem_addra), 32'(exp_pa));
            check_eq("wb_dina", mem_dina, exp_data);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] g_vec [8];
        int         g_cyc [8];
        logic [3:0] exp_vec [5];
        int         n_g;
        int         last_g;
        logic       seen;

        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_addr  = '0;
        req_data  = '0;
        req_page  = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_resp_data", resp_data, 32'd0);
        check_eq("rst_flags", {30'd0, resp_overflow, resp_err}, 32'd0);
        check_eq("rst_wea", 32'(mem_wea), 32'd0);
        check_eq("rst_addra", 32'(mem_addra), 32'd0);
        check_eq("rst_addrb", 32'(mem_addrb), 32'd0);
        check_eq("rst_dina", mem_dina, 32'd0);
        rst = 1'b0;

        // store/load through page {len 8, base 4}
        txn(0, 8'h08, 5'd3, 32'hAB, {8'd8, 8'd4}, 5'd7, 1'b1, 32'hAB, 1'b0, 1'b0, 1'b1);
        txn(0, 8'h0B, 5'd3, 32'h0, {8'd8, 8'd4}, 5'd7, 1'b1, 32'hAB, 1'b0, 1'b0, 1'b0);

        // loadd wraps all-ones to zero, then increments
        txn(1, 8'h08, 5'd0, 32'hFFFF_FFFF, {8'd8, 8'd10}, 5'd10, 1'b1, 32'hFFFF_FFFF,
            1'b0, 1'b0, 1'b1);
        txn(1, 8'h07, 5'd0, 32'h0, {8'd8, 8'd10}, 5'd10, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
        txn(1, 8'h07, 5'd0, 32'h0, {8'd8, 8'd10}, 5'd10, 1'b1, 32'h1, 1'b0, 1'b0, 1'b1);

        // bounds: addr 9 > len 8 overflows only when the check is built in; addr 8 is legal
        txn(2, 8'h08, 5'd9, 32'h55, {8'd8, 8'd0}, 5'd9, 1'b1, BC ? 32'h0 : 32'h55,
            BC, 1'b0, !BC);
        txn(2, 8'h08, 5'd8, 32'h66, {8'd8, 8'd0}, 5'd8, 1'b1, 32'h66, 1'b0, 1'b0, 1'b1);

        // physical address wrap: base 30 + addr 4 -> 2
        txn(3, 8'h08, 5'd4, 32'h1234, {8'd8, 8'd30}, 5'd2, 1'b1, 32'h1234, 1'b0, 1'b0, 1'b1);
        txn(3, 8'h0B, 5'd4, 32'h0, {8'd8, 8'd30}, 5'd2, 1'b1, 32'h1234, 1'b0, 1'b0, 1'b0);

        // unsupported opcode: no RAM access, error flag, zero data
        txn(0, 8'h01, 5'd1, 32'hDEAD, {8'd8, 8'd0}, 5'd1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // all four contend from pointer 0; requester 2 re-requests after its grant
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_op[i*8 +: 8]    = 8'h0B;
            req_addr[i*5 +: 5]  = 5'(i);
            req_page[i*16 +: 16] = {8'd8, 8'd0};
        end
        n_g    = 0;
        last_g = -1;
        for (int cyc = 0; cyc < 21; cyc++) begin
            @(negedge clk);
            if (last_g >= 0) begin
                req_valid[last_g] = 1'b0;
                last_g = -1;
            end
            if (cyc == 0) req_valid = 4'hF;
            if (cyc == 9) req_valid[2] = 1'b1;
            #1;
            if (req_ready != 4'b0) begin
                if (n_g < 8) begin
                    g_vec[n_g] = req_ready;
                    g_cyc[n_g] = cyc;
                end
                n_g++;
                for (int i = 0; i < 4; i++) begin
                    if (req_ready[i]) last_g = i;
                end
            end
        end
        req_valid = '0;
        exp_vec = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};
        check_eq("rr_grant_count", 32'(n_g), 32'd5);
        for (int k = 0; k < 5 && k < n_g; k++) begin
            check_eq("rr_grant_vec", 32'(g_vec[k]), 32'(exp_vec[k]));
            check_eq("rr_grant_cycle", 32'(g_cyc[k]), 32'(4 * k));
        end

        // reset while in CAP: pointer was 3, requester 1 wins and moves it to 2
        @(negedge clk);
        req_op[8 +: 8] = 8'h07;
        req_valid[1]   = 1'b1;
        #1;
        check_eq("midrst_ready", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_resp", 32'(resp_valid), 32'd0);
        check_eq("midrst_wea", 32'(mem_wea), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid != 4'b0 || mem_wea) seen = 1'b1;
        end
        check_eq("midrst_dropped", 32'(seen), 32'd0);
        @(negedge clk);
        req_valid = 4'b1001;
        #1;
        check_eq("midrst_ptr_reset", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
